// File: rtl/genome_commit_ctrl.sv
// Genome handoff controller: loader monitor, core drain, atomic cfg commit,
// settle/restart sequencing and sticky OTP lock.
module genome_commit_ctrl #(
    parameter int LOAD_TIMEOUT  = 27000000,
    parameter int DRAIN_TIMEOUT = 4096,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_busy,
    input  logic         ld_core_enable,
    input  logic [31:0]  ld_freq,
    input  logic [31:0]  ld_seed,
    input  logic [255:0] ld_dna,
    input  logic         ld_otp_en,
    input  logic         core_idle,
    input  logic         cfg_ready,
    output logic         cfg_valid,
    output logic [31:0]  cfg_freq,
    output logic [31:0]  cfg_seed,
    output logic [255:0] cfg_dna,
    output logic         core_run,
    output logic         otp_locked,
    output logic         err_timeout,
    output logic         err_locked,
    output logic [7:0]   commit_count,
    output logic [2:0]   ctrl_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOADING = 3'd1,
        S_DRAIN   = 3'd2,
        S_COMMIT  = 3'd3,
        S_SETTLE  = 3'd4,
        S_RUN     = 3'd5
    } state_t;

    localparam int TMAX = (LOAD_TIMEOUT > DRAIN_TIMEOUT) ? LOAD_TIMEOUT : DRAIN_TIMEOUT;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam int SW   = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [TW-1:0] LOAD_LAST   = TW'(LOAD_TIMEOUT - 1);
    localparam logic [TW-1:0] DRAIN_LAST  = TW'(DRAIN_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_t         state, state_n;
    logic [TW-1:0]  timer, timer_n;
    logic [SW-1:0]  settle, settle_n;
    logic           done_q;
    logic           done_rise;
    logic           have_genome;
    logic           set_tmo, set_lck, latch, commit;
    state_t         back;

    logic [31:0]    sh_freq, sh_seed, cm_freq, cm_seed;
    logic [255:0]   sh_dna, cm_dna;
    logic           sh_otp;

    assign done_rise = ld_core_enable & ~done_q;
    assign back      = have_genome ? S_RUN : S_IDLE;

    always_comb begin
        state_n  = state;
        timer_n  = '0;
        settle_n = '0;
        set_tmo  = 1'b0;
        set_lck  = 1'b0;
        latch    = 1'b0;
        commit   = 1'b0;
        unique case (state)
            S_IDLE, S_RUN: begin
                if (ld_busy) state_n = S_LOADING;
            end
            S_LOADING: begin
                timer_n = timer + 1'b1;
                // A completed genome wins over a simultaneous timeout
                if (done_rise) begin
                    timer_n = '0;
                    if (otp_locked) begin
                        set_lck = 1'b1;
                        state_n = back;
                    end else begin
                        latch   = 1'b1;
                        state_n = S_DRAIN;
                    end
                end else if (!ld_busy) begin
                    state_n = back;
                end else if (timer == LOAD_LAST) begin
                    set_tmo = 1'b1;
                    state_n = back;
                end
            end
            S_DRAIN: begin
                timer_n = timer + 1'b1;
                if (core_idle) begin
                    state_n = S_COMMIT;
                end else if (timer == DRAIN_LAST) begin
                    set_tmo = 1'b1;
                    state_n = back;
                end
            end
            S_COMMIT: begin
                if (cfg_ready) begin
                    commit  = 1'b1;
                    state_n = S_SETTLE;
                end
            end
            S_SETTLE: begin
                settle_n = settle + 1'b1;
                if (settle == SETTLE_LAST) state_n = S_RUN;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            timer        <= '0;
            settle       <= '0;
            done_q       <= 1'b0;
            have_genome  <= 1'b0;
            otp_locked   <= 1'b0;
            err_timeout  <= 1'b0;
            err_locked   <= 1'b0;
            commit_count <= '0;
            sh_freq      <= '0;
            sh_seed      <= 32'h12345678;
            sh_dna       <= '0;
            sh_otp       <= 1'b0;
            cm_freq      <= '0;
            cm_seed      <= 32'h12345678;
            cm_dna       <= '0;
        end else begin
            state  <= state_n;
            timer  <= timer_n;
            settle <= settle_n;
            done_q <= ld_core_enable;
            if (set_tmo) err_timeout <= 1'b1;
            if (set_lck) err_locked <= 1'b1;
            if (latch) begin
                sh_freq <= ld_freq;
                sh_seed <= ld_seed;
                sh_dna  <= ld_dna;
                sh_otp  <= ld_otp_en;
            end
            if (commit) begin
                cm_freq     <= sh_freq;
                cm_seed     <= sh_seed;
                cm_dna      <= sh_dna;
                have_genome <= 1'b1;
                otp_locked  <= otp_locked | sh_otp;
                if (commit_count != 8'hFF) commit_count <= commit_count + 1'b1;
            end
        end
    end

    // While offering, the bus shows the pending genome; otherwise the last commit
    assign cfg_valid  = (state == S_COMMIT);
    assign cfg_freq   = cfg_valid ? sh_freq : cm_freq;
    assign cfg_seed   = cfg_valid ? sh_seed : cm_seed;
    assign cfg_dna    = cfg_valid ? sh_dna : cm_dna;
    assign core_run   = (state == S_RUN) | ((state == S_LOADING) & have_genome);
    assign ctrl_state = state;

endmodule

// File: tb/tb_genome_commit_ctrl.sv
// Directed bench for genome_commit_ctrl: table of load transactions plus
// hand sequences for timeouts, async reset in COMMIT and count saturation.
module tb_genome_commit_ctrl;

    localparam int LT = 64;
    localparam int DT = 32;
    localparam int ST = 4;

    logic         clk, rst_n;
    logic         ld_busy, ld_core_enable, ld_otp_en, core_idle, cfg_ready;
    logic [31:0]  ld_freq, ld_seed;
    logic [255:0] ld_dna;
    logic         cfg_valid, core_run, otp_locked, err_timeout, err_locked;
    logic [31:0]  cfg_freq, cfg_seed;
    logic [255:0] cfg_dna;
    logic [7:0]   commit_count;
    logic [2:0]   ctrl_state;

    int tests = 0;
    int fails = 0;

    genome_commit_ctrl #(
        .LOAD_TIMEOUT (LT),
        .DRAIN_TIMEOUT(DT),
        .SETTLE_CYCLES(ST)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_busy       (ld_busy),
        .ld_core_enable(ld_core_enable),
        .ld_freq       (ld_freq),
        .ld_seed       (ld_seed),
        .ld_dna        (ld_dna),
        .ld_otp_en     (ld_otp_en),
        .core_idle     (core_idle),
        .cfg_ready     (cfg_ready),
        .cfg_valid     (cfg_valid),
        .cfg_freq      (cfg_freq),
        .cfg_seed      (cfg_seed),
        .cfg_dna       (cfg_dna),
        .core_run      (core_run),
        .otp_locked    (otp_locked),
        .err_timeout   (err_timeout),
        .err_locked    (err_locked),
        .commit_count  (commit_count),
        .ctrl_state    (ctrl_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0]  freq;
        logic [31:0]  seed;
        logic [255:0] dna;
        logic         otp;
        int           idle_w;
        int           rdy_w;
        logic         exp_acc;
        logic [7:0]   exp_cnt;
        logic         exp_lock;
        logic         exp_errl;
        logic [31:0]  exp_freq;
    } vec_t;

    vec_t vt[4];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drives one genome load; handshake only if the DUT reaches DRAIN
    task automatic run_load(
        input  logic [31:0]  f,
        input  logic [31:0]  s,
        input  logic [255:0] d,
        input  logic         otp,
        input  int           idle_w,
        input  int           rdy_w,
        output logic         accepted,
        output int           settle_n,
        output logic         stable,
        output logic         vdrop
    );
        ld_freq   = f;
        ld_seed   = s;
        ld_dna    = d;
        ld_otp_en = otp;
        core_idle = 1'b0;
        cfg_ready = 1'b0;
        ld_busy   = 1'b1;
        tick(3);
        ld_core_enable = 1'b1;
        ld_busy        = 1'b0;
        tick(1);
        ld_core_enable = 1'b0;
        accepted = 1'b0;
        settle_n = 0;
        stable   = 1'b1;
        vdrop    = 1'b0;
        if (ctrl_state == 3'd2) begin
            repeat (idle_w) tick(1);
            core_idle = 1'b1;
            tick(1);
            core_idle = 1'b0;
            repeat (rdy_w) begin
                if (!cfg_valid || cfg_freq != f || cfg_seed != s || cfg_dna != d)
                    stable = 1'b0;
                tick(1);
            end
            if (!cfg_valid || cfg_freq != f || cfg_seed != s || cfg_dna != d)
                stable = 1'b0;
            cfg_ready = 1'b1;
            tick(1);
            cfg_ready = 1'b0;
            accepted  = 1'b1;
            vdrop     = !cfg_valid;
            while (!core_run && settle_n < 100) begin
                tick(1);
                settle_n++;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    logic acc, stab, vd, bad;
    int   sn, n;

    initial begin
        vt[0] = '{32'h0000_1000, 32'hAAAA_0001, {8{32'h1111_2222}}, 1'b0, 0, 0,
                  1'b1, 8'd1, 1'b0, 1'b0, 32'h0000_1000};
        vt[1] = '{32'h0000_2000, 32'hBBBB_0002, {8{32'h3333_4444}}, 1'b0, 3, 10,
                  1'b1, 8'd2, 1'b0, 1'b0, 32'h0000_2000};
        vt[2] = '{32'h0000_3000, 32'hCCCC_0003, {8{32'h5555_6666}}, 1'b1, 1, 2,
                  1'b1, 8'd3, 1'b1, 1'b0, 32'h0000_3000};
        vt[3] = '{32'h0000_4000, 32'hDDDD_0004, {8{32'h7777_8888}}, 1'b0, 0, 0,
                  1'b0, 8'd3, 1'b1, 1'b1, 32'h0000_3000};

        rst_n = 1'b0;
        ld_busy = 1'b0;
        ld_core_enable = 1'b0;
        ld_freq = '0;
        ld_seed = '0;
        ld_dna = '0;
        ld_otp_en = 1'b0;
        core_idle = 1'b0;
        cfg_ready = 1'b0;
        tick(2);
        chk("rst_seed", cfg_seed, 32'h12345678);
        chk("rst_freq", cfg_freq, 0);
        chk("rst_dna", cfg_dna, 0);
        chk("rst_valid", cfg_valid, 0);
        chk("rst_run", core_run, 0);
        chk("rst_state", ctrl_state, 0);
        chk("rst_count", commit_count, 0);
        chk("rst_flags", {otp_locked, err_timeout, err_locked}, 0);
        rst_n = 1'b1;
        tick(1);

        for (int i = 0; i < 4; i++) begin
            run_load(vt[i].freq, vt[i].seed, vt[i].dna, vt[i].otp,
                     vt[i].idle_w, vt[i].rdy_w, acc, sn, stab, vd);
            tick(1);
            chk($sformatf("v%0d_accept", i), acc, vt[i].exp_acc);
            chk($sformatf("v%0d_count", i), commit_count, vt[i].exp_cnt);
            chk($sformatf("v%0d_otp", i), otp_locked, vt[i].exp_lock);
            chk($sformatf("v%0d_errl", i), err_locked, vt[i].exp_errl);
            chk($sformatf("v%0d_freq", i), cfg_freq, vt[i].exp_freq);
            chk($sformatf("v%0d_run", i), core_run, 1);
            chk($sformatf("v%0d_state", i), ctrl_state, 5);
            if (vt[i].exp_acc) begin
                chk($sformatf("v%0d_settle", i), sn, ST);
                chk($sformatf("v%0d_stable", i), stab, 1);
                chk($sformatf("v%0d_vdrop", i), vd, 1);
                chk($sformatf("v%0d_seed", i), cfg_seed, vt[i].seed);
                chk($sformatf("v%0d_dna", i), cfg_dna, vt[i].dna);
            end
        end

        // Load timeout from IDLE
        do_reset();
        ld_busy = 1'b1;
        tick(1);
        n = 0;
        bad = 1'b0;
        while (ctrl_state == 3'd1 && n < 200) begin
            if (cfg_valid) bad = 1'b1;
            n++;
            tick(1);
        end
        ld_busy = 1'b0;
        chk("ltmo_cycles", n, LT);
        chk("ltmo_err", err_timeout, 1);
        chk("ltmo_state", ctrl_state, 0);
        chk("ltmo_novalid", bad, 0);
        tick(2);
        chk("ltmo_stays_idle", ctrl_state, 0);

        // Drain timeout after one good commit
        run_load(32'h0000_5000, 32'hEEEE_0005, {8{32'h9999_AAAA}}, 1'b0, 0, 0, acc, sn, stab, vd);
        tick(1);
        chk("pre_drain_count", commit_count, 1);
        ld_freq = 32'hDEAD_BEEF;
        ld_busy = 1'b1;
        tick(2);
        chk("load_run_kept", core_run, 1);
        ld_core_enable = 1'b1;
        ld_busy = 1'b0;
        tick(1);
        ld_core_enable = 1'b0;
        n = 0;
        bad = 1'b0;
        while (ctrl_state == 3'd2 && n < 100) begin
            if (core_run) bad = 1'b1;
            n++;
            tick(1);
        end
        chk("dtmo_cycles", n, DT);
        chk("dtmo_run_low", bad, 0);
        chk("dtmo_err", err_timeout, 1);
        chk("dtmo_state", ctrl_state, 5);
        chk("dtmo_run_back", core_run, 1);
        chk("dtmo_freq", cfg_freq, 32'h0000_5000);
        chk("dtmo_count", commit_count, 1);

        // Async reset while offering in COMMIT
        ld_busy = 1'b1;
        tick(2);
        ld_core_enable = 1'b1;
        ld_busy = 1'b0;
        tick(1);
        ld_core_enable = 1'b0;
        core_idle = 1'b1;
        tick(1);
        core_idle = 1'b0;
        chk("t5_in_commit", cfg_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", cfg_valid, 0);
        chk("t5_state", ctrl_state, 0);
        chk("t5_seed", cfg_seed, 32'h12345678);
        chk("t5_count", commit_count, 0);
        chk("t5_errt", err_timeout, 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Saturation of the commit counter
        for (int i = 0; i < 256; i++) begin
            run_load(i, ~i, '0, 1'b0, 0, 0, acc, sn, stab, vd);
            if (i == 254) chk("sat_255", commit_count, 255);
        end
        tick(1);
        chk("sat_hold", commit_count, 255);
        chk("sat_freq", cfg_freq, 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
